// File: rtl/bus_sequencer_if.sv
// Control/strobe bundle between the bus sequencer (master) and the shared-bus datapath (slave).
interface bus_sequencer_if #(
  parameter int OPC_W = 4,
  parameter int T_W   = 3
);
  logic             clr;
  logic             program_mode;
  logic [OPC_W-1:0] opcode;
  logic             carry_flag;
  logic             zero_flag;

  logic             pc_out;
  logic             pc_inc;
  logic             pc_load;
  logic             mar_in;
  logic             ram_out;
  logic             ram_in;
  logic             ir_in;
  logic             ir_out;
  logic             a_in;
  logic             a_out;
  logic             b_in;
  logic             alu_out;
  logic             alu_sub;
  logic             flags_in;
  logic             out_in;
  logic             halted;
  logic [T_W-1:0]   t_state;

  modport master (
    input  clr, program_mode, opcode, carry_flag, zero_flag,
    output pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
           a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halted, t_state
  );

  modport slave (
    output clr, program_mode, opcode, carry_flag, zero_flag,
    input  pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
           a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halted, t_state
  );
endinterface

// File: rtl/bus_sequencer.sv
// Microcode-style T-state sequencer for the 8-bit shared-bus datapath; sole owner of all bus strobes.
//   state | meaning
//   T0    | fetch: PC -> MAR
//   T1    | fetch: RAM -> IR, PC++
//   T2    | execute step 1 (also the parking state while halted)
//   T3    | execute step 2 (LDA/ADD/SUB/STA)
//   T4    | execute step 3 (ADD/SUB)
module bus_sequencer #(
  parameter int OPC_W = 4,
  parameter int T_W   = 3
) (
  input  logic           clk,
  input  logic           rst,
  bus_sequencer_if.master bus
);

  localparam logic [T_W-1:0] T0 = T_W'(0);
  localparam logic [T_W-1:0] T1 = T_W'(1);
  localparam logic [T_W-1:0] T2 = T_W'(2);
  localparam logic [T_W-1:0] T3 = T_W'(3);
  localparam logic [T_W-1:0] T4 = T_W'(4);

  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'h0);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4'h3);
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(4'h4);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'h5);
  localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(4'h6);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(4'h7);
  localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(4'hE);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'hF);

  logic [T_W-1:0] r_t;
  logic           r_halted;
  logic [T_W-1:0] w_t_nxt;
  logic           w_halted_nxt;
  logic           w_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t      <= T0;
      r_halted <= 1'b0;
    end else begin
      r_t      <= w_t_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  always_comb begin
    w_t_nxt      = r_t;
    w_halted_nxt = r_halted;
    if (bus.clr) begin
      w_t_nxt      = T0;
      w_halted_nxt = 1'b0;
    end else if (!bus.program_mode && !r_halted) begin
      case (r_t)
        T0: w_t_nxt = T1;
        T1: w_t_nxt = T2;
        T2: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: w_t_nxt = T3;
            OP_HLT: begin
              w_t_nxt      = T2;
              w_halted_nxt = 1'b1;
            end
            default: w_t_nxt = T0;
          endcase
        end
        T3: w_t_nxt = (bus.opcode == OP_ADD || bus.opcode == OP_SUB) ? T4 : T0;
        default: w_t_nxt = T0;
      endcase
    end
  end

  // rst gates the decode so nothing strobes while reset is held, even though r_t already reads T0
  assign w_active = !rst && !bus.program_mode && !r_halted;

  always_comb begin
    bus.pc_out   = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.pc_load  = 1'b0;
    bus.mar_in   = 1'b0;
    bus.ram_out  = 1'b0;
    bus.ram_in   = 1'b0;
    bus.ir_in    = 1'b0;
    bus.ir_out   = 1'b0;
    bus.a_in     = 1'b0;
    bus.a_out    = 1'b0;
    bus.b_in     = 1'b0;
    bus.alu_out  = 1'b0;
    bus.alu_sub  = 1'b0;
    bus.flags_in = 1'b0;
    bus.out_in   = 1'b0;
    if (w_active) begin
      case (r_t)
        T0: begin
          bus.pc_out = 1'b1;
          bus.mar_in = 1'b1;
        end
        T1: begin
          bus.ram_out = 1'b1;
          bus.ir_in   = 1'b1;
          bus.pc_inc  = 1'b1;
        end
        T2: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              bus.ir_out = 1'b1;
              bus.mar_in = 1'b1;
            end
            OP_LDI: begin
              bus.ir_out = 1'b1;
              bus.a_in   = 1'b1;
            end
            OP_JMP: begin
              bus.ir_out  = 1'b1;
              bus.pc_load = 1'b1;
            end
            OP_JC: begin
              bus.ir_out  = bus.carry_flag;
              bus.pc_load = bus.carry_flag;
            end
            OP_JZ: begin
              bus.ir_out  = bus.zero_flag;
              bus.pc_load = bus.zero_flag;
            end
            OP_OUT: begin
              bus.a_out  = 1'b1;
              bus.out_in = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (bus.opcode)
            OP_LDA: begin
              bus.ram_out = 1'b1;
              bus.a_in    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              bus.ram_out = 1'b1;
              bus.b_in    = 1'b1;
            end
            OP_STA: begin
              bus.a_out  = 1'b1;
              bus.ram_in = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            bus.alu_out  = 1'b1;
            bus.a_in     = 1'b1;
            bus.flags_in = 1'b1;
            bus.alu_sub  = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.halted  = r_halted;
  assign bus.t_state = r_t;

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer: directed instruction vectors, then a random stream with invariant checks.
module tb_bus_sequencer;

  localparam logic [14:0] PC_OUT   = 15'h4000;
  localparam logic [14:0] PC_INC   = 15'h2000;
  localparam logic [14:0] PC_LOAD  = 15'h1000;
  localparam logic [14:0] MAR_IN   = 15'h0800;
  localparam logic [14:0] RAM_OUT  = 15'h0400;
  localparam logic [14:0] RAM_IN   = 15'h0200;
  localparam logic [14:0] IR_IN    = 15'h0100;
  localparam logic [14:0] IR_OUT   = 15'h0080;
  localparam logic [14:0] A_IN     = 15'h0040;
  localparam logic [14:0] A_OUT    = 15'h0020;
  localparam logic [14:0] B_IN     = 15'h0010;
  localparam logic [14:0] ALU_OUT  = 15'h0008;
  localparam logic [14:0] ALU_SUB  = 15'h0004;
  localparam logic [14:0] FLAGS_IN = 15'h0002;
  localparam logic [14:0] OUT_IN   = 15'h0001;
  localparam logic [14:0] NONE     = 15'h0000;

  typedef struct {
    string       name;
    logic [2:0]  t;
    logic [14:0] s;
    logic        h;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;
  bit   rnd_en = 1'b0;

  bus_sequencer_if #(.OPC_W(4), .T_W(3)) u_if ();
  bus_sequencer #(.OPC_W(4), .T_W(3)) u_dut (.clk(clk), .rst(rst), .bus(u_if));

  always #5 clk = ~clk;

  function automatic logic [14:0] strobes();
    return {u_if.pc_out, u_if.pc_inc, u_if.pc_load, u_if.mar_in, u_if.ram_out,
            u_if.ram_in, u_if.ir_in, u_if.ir_out, u_if.a_in, u_if.a_out,
            u_if.b_in, u_if.alu_out, u_if.alu_sub, u_if.flags_in, u_if.out_in};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL sb_empty: monitor had no expected entry at t=%0t", $time);
      end else begin
        e = sb_q.pop_front();
        if (u_if.t_state !== e.t || strobes() !== e.s || u_if.halted !== e.h) begin
          fails++;
          $display("FAIL %s: got t=%0d s=%h h=%b, want t=%0d s=%h h=%b",
                   e.name, u_if.t_state, strobes(), u_if.halted, e.t, e.s, e.h);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rnd_en) begin
      tests += 2;
      if ($countones({u_if.pc_out, u_if.ram_out, u_if.ir_out, u_if.a_out, u_if.alu_out}) > 1) begin
        fails++;
        $display("FAIL bus_onehot: drivers=%b, want at most one", {u_if.pc_out, u_if.ram_out, u_if.ir_out, u_if.a_out, u_if.alu_out});
      end
      if (u_if.pc_load && u_if.pc_inc) begin
        fails++;
        $display("FAIL pc_load_inc: pc_load=%b pc_inc=%b, want not both", u_if.pc_load, u_if.pc_inc);
      end
    end
  end

  task automatic step(input string name, input logic [3:0] op, input logic cf, input logic zf,
                      input logic pm, input logic cl, input logic [2:0] t, input logic [14:0] s,
                      input logic h);
    exp_t e;
    u_if.opcode       = op;
    u_if.carry_flag   = cf;
    u_if.zero_flag    = zf;
    u_if.program_mode = pm;
    u_if.clr          = cl;
    e.name = name;
    e.t    = t;
    e.s    = s;
    e.h    = h;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string name, input logic [3:0] op);
    step({name, "_t0"}, op, 0, 0, 0, 0, 3'd0, PC_OUT | MAR_IN, 0);
    step({name, "_t1"}, op, 0, 0, 0, 0, 3'd1, RAM_OUT | IR_IN | PC_INC, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.opcode = 4'h0; u_if.carry_flag = 0; u_if.zero_flag = 0;
    u_if.program_mode = 0; u_if.clr = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    step("reset", 4'h0, 0, 0, 0, 0, 3'd0, NONE, 0);
    rst = 1'b0;

    fetch("ldi", 4'h4);
    step("ldi_t2", 4'h4, 0, 0, 0, 0, 3'd2, IR_OUT | A_IN, 0);

    fetch("add", 4'h1);
    step("add_t2", 4'h1, 0, 0, 0, 0, 3'd2, IR_OUT | MAR_IN, 0);
    step("add_t3", 4'h1, 0, 0, 0, 0, 3'd3, RAM_OUT | B_IN, 0);
    step("add_t4", 4'h1, 0, 0, 0, 0, 3'd4, ALU_OUT | A_IN | FLAGS_IN, 0);

    fetch("sub", 4'h2);
    step("sub_t2", 4'h2, 0, 0, 0, 0, 3'd2, IR_OUT | MAR_IN, 0);
    step("sub_t3", 4'h2, 0, 0, 0, 0, 3'd3, RAM_OUT | B_IN, 0);
    step("sub_t4", 4'h2, 0, 0, 0, 0, 3'd4, ALU_OUT | A_IN | FLAGS_IN | ALU_SUB, 0);

    fetch("sta", 4'h3);
    step("sta_t2", 4'h3, 0, 0, 0, 0, 3'd2, IR_OUT | MAR_IN, 0);
    step("sta_t3", 4'h3, 0, 0, 0, 0, 3'd3, A_OUT | RAM_IN, 0);

    fetch("jmp", 4'h5);
    step("jmp_t2", 4'h5, 0, 0, 0, 0, 3'd2, IR_OUT | PC_LOAD, 0);

    fetch("jc0", 4'h6);
    step("jc0_t2", 4'h6, 0, 1, 0, 0, 3'd2, NONE, 0);
    fetch("jc1", 4'h6);
    step("jc1_t2", 4'h6, 1, 0, 0, 0, 3'd2, IR_OUT | PC_LOAD, 0);
    fetch("jz0", 4'h7);
    step("jz0_t2", 4'h7, 1, 0, 0, 0, 3'd2, NONE, 0);
    fetch("jz1", 4'h7);
    step("jz1_t2", 4'h7, 0, 1, 0, 0, 3'd2, IR_OUT | PC_LOAD, 0);

    fetch("out", 4'hE);
    step("out_t2", 4'hE, 0, 0, 0, 0, 3'd2, A_OUT | OUT_IN, 0);
    fetch("nop", 4'h9);
    step("nop_t2", 4'h9, 0, 0, 0, 0, 3'd2, NONE, 0);

    fetch("lda_pm", 4'h0);
    step("lda_pm_t2", 4'h0, 0, 0, 0, 0, 3'd2, IR_OUT | MAR_IN, 0);
    for (int i = 0; i < 10; i++) step("lda_pm_hold", 4'h0, 0, 0, 1, 0, 3'd3, NONE, 0);
    step("lda_pm_t3", 4'h0, 0, 0, 0, 0, 3'd3, RAM_OUT | A_IN, 0);

    step("clrpm_t0", 4'h4, 0, 0, 0, 0, 3'd0, PC_OUT | MAR_IN, 0);
    step("clrpm_both", 4'h4, 0, 0, 1, 1, 3'd1, NONE, 0);
    fetch("clrpm_after", 4'h4);
    step("clrpm_after_t2", 4'h4, 0, 0, 0, 0, 3'd2, IR_OUT | A_IN, 0);

    fetch("hlt", 4'hF);
    step("hlt_t2", 4'hF, 0, 0, 0, 0, 3'd2, NONE, 0);
    for (int i = 0; i < 20; i++) step("hlt_stuck", 4'h4, 1, 1, 0, 0, 3'd2, NONE, 1);
    step("hlt_clr", 4'h4, 0, 0, 0, 1, 3'd2, NONE, 1);
    fetch("post_hlt", 4'h4);
    step("post_hlt_t2", 4'h4, 0, 0, 0, 0, 3'd2, IR_OUT | A_IN, 0);

    fetch("rst_mid", 4'h1);
    step("rst_mid_t2", 4'h1, 0, 0, 0, 0, 3'd2, IR_OUT | MAR_IN, 0);
    rst = 1'b1;
    step("rst_mid_rst", 4'h1, 0, 0, 0, 0, 3'd0, NONE, 0);
    rst = 1'b0;
    fetch("rst_after", 4'h4);
    step("rst_after_t2", 4'h4, 0, 0, 0, 0, 3'd2, IR_OUT | A_IN, 0);

    chk_en = 1'b0;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb_q.size());
    end

    rnd_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      rst = 1'b0;
      u_if.opcode       = 4'($urandom_range(0, 15));
      u_if.carry_flag   = 1'($urandom_range(0, 1));
      u_if.zero_flag    = 1'($urandom_range(0, 1));
      u_if.program_mode = ($urandom_range(0, 15) == 0);
      u_if.clr          = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        #1;
        tests++;
        if (strobes() !== NONE || u_if.t_state !== 3'd0 || u_if.halted !== 1'b0) begin
          fails++;
          $display("FAIL rnd_rst: s=%h t=%0d h=%b, want s=0000 t=0 h=0", strobes(), u_if.t_state, u_if.halted);
        end
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    rnd_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
